// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_tx_if
//  Description : Handshake and serial-line bundle for serial_frame_tx.
//                The master side offers a word with data_in/load and
//                observes ready/sdata/busy/done. The slave side is the
//                transmitter itself.
//  Signals     : data_in [WIDTH] word to transmit (master -> slave)
//                load            request to send data_in (master -> slave)
//                ready           transmitter accepts a load (slave -> master)
//                sdata           serial line, idle high (slave -> master)
//                busy            frame in progress (slave -> master)
//                done            end-of-stop-bit pulse (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             sdata;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load,
        input  ready,
        input  sdata,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load,
        output ready,
        output sdata,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_tx
//  Description : Parallel-to-serial frame transmitter. Accepts a WIDTH-bit
//                word on a load/ready handshake and sends one start bit (0),
//                WIDTH data bits LSB first and one stop bit (1), each held
//                for DIV clock cycles. All outputs are registered.
//  Ports       : clk     system clock, rising edge
//                rst     synchronous active-high reset
//                tx_bus  serial_frame_tx_if.slave
//                        (data_in, load in; ready, sdata, busy, done out)
//  Options     : SERIAL_FRAME_TX_PARITY_EN - when defined, an even-parity
//                bit (XOR of the accepted word) is sent between the last
//                data bit and the stop bit, lengthening each frame by DIV
//                cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  wire              clk,
    input  wire              rst,
    serial_frame_tx_if.slave tx_bus
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               sdata_q, sdata_d;
    logic               ready_q, ready_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               bit_end;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            sdata_q  <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            sdata_q  <= sdata_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_end  = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (tx_bus.load) begin
                    state_d  = START;
                    shift_d  = tx_bus.data_in;
                    cnt_d    = '0;
                    idx_d    = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d = ^tx_bus.data_in;
`endif
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Outputs are decoded from the upcoming state so that, once
        // registered, they line up with the state they describe.
        case (state_d)
            START:   sdata_d = 1'b0;
            DATA:    sdata_d = shift_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY:  sdata_d = parity_d;
`endif
            default: sdata_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        // High during the last cycle of the stop bit; with DIV=1 that is
        // the first STOP cycle as well.
        done_d  = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    assign tx_bus.sdata = sdata_q;
    assign tx_bus.ready = ready_q;
    assign tx_bus.busy  = busy_q;
    assign tx_bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_tx
//  Description : Directed self-checking bench for serial_frame_tx. Frames
//                are compared cycle by cycle against expected bit patterns
//                computed from the word, WIDTH and DIV.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    localparam int WIDTH = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int DIV   = 1;
    localparam int FLEN  = WIDTH + 3;
`else
    localparam int DIV   = 4;
    localparam int FLEN  = WIDTH + 2;
`endif
    localparam int FCYC  = FLEN * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    serial_frame_tx_if #(.WIDTH(WIDTH)) tx_if ();

    serial_frame_tx #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tx_bus (tx_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected line level for frame position pos (0 = start bit).
    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int pos);
        if (pos == 0)
            return 1'b0;
        else if (pos <= WIDTH)
            return w[pos-1];
`ifdef SERIAL_FRAME_TX_PARITY_EN
        else if (pos == WIDTH + 1)
            return ^w;
`endif
        else
            return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check_val({tag, "_sdata"}, 32'(tx_if.sdata), 32'd1);
        check_val({tag, "_ready"}, 32'(tx_if.ready), 32'd1);
        check_val({tag, "_busy"},  32'(tx_if.busy),  32'd0);
        check_val({tag, "_done"},  32'(tx_if.done),  32'd0);
    endtask

    // Entered at a negedge inside an idle cycle; loads w there and checks
    // the whole frame. inject_cyc > 0 pulses a load of 0x00 during that
    // frame cycle; rst_cyc > 0 asserts reset at that frame cycle and stops
    // checking the frame. Leaves off at a negedge in the first idle cycle.
    task automatic send_frame(input logic [WIDTH-1:0] w, input int inject_cyc,
                              input int rst_cyc);
        check_val("accept_ready", 32'(tx_if.ready), 32'd1);
        tx_if.data_in = w;
        tx_if.load    = 1'b1;
        @(negedge clk);
        tx_if.load    = 1'b0;
        tx_if.data_in = ~w;
        for (int c = 1; c <= FCYC; c++) begin
            if (c == rst_cyc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle("rst_mid");
                return;
            end
            check_val("sdata", 32'(tx_if.sdata), 32'(exp_bit(w, (c - 1) / DIV)));
            check_val("busy",  32'(tx_if.busy),  32'd1);
            check_val("ready", 32'(tx_if.ready), 32'd0);
            check_val("done",  32'(tx_if.done),  32'(c == FCYC));
            if (c == inject_cyc) begin
                tx_if.data_in = '0;
                tx_if.load    = 1'b1;
            end
            @(negedge clk);
            tx_if.load = 1'b0;
        end
        check_idle("post");
    endtask

    initial begin
        tx_if.data_in = '0;
        tx_if.load    = 1'b0;

        // Reset, including load held high during reset (must not be taken).
        repeat (2) @(negedge clk);
        tx_if.load    = 1'b1;
        tx_if.data_in = 8'h5A;
        @(negedge clk);
        check_idle("in_reset");
        rst = 1'b0;
        tx_if.load = 1'b0;

        for (int i = 0; i < 10; i++) begin
            check_idle("idle");
            @(negedge clk);
        end

`ifdef SERIAL_FRAME_TX_PARITY_EN
        send_frame(8'h07, 0, 0);
        @(negedge clk);
`endif
        send_frame(8'hA5, 0, 0);
        @(negedge clk);

        // Back-to-back: second load lands in the first ready cycle.
        send_frame(8'h3C, 0, 0);
        send_frame(8'hFF, 0, 0);
        @(negedge clk);

        // Load pulsed during data bit 3 must be ignored.
        send_frame(8'h81, 4 * DIV + 1 + (DIV > 1 ? 1 : 0), 0);
        @(negedge clk);

        // Reset during data bit 5, then a clean frame.
        send_frame(8'hF0, 0, 6 * DIV + 1);
        for (int i = 0; i < FCYC; i++) begin
            check_val("no_done_after_rst", 32'(tx_if.done), 32'd0);
            @(negedge clk);
        end
        send_frame(8'h55, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
